// File: rtl/matrix_alu_pkg.sv
// Shared definitions for the matrix ALU bus initiator: op codes, address select codes,
// controller state encodings and the bus address builder.
package matrix_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_MUL    = 4'd2,
    OP_TRANS  = 4'd3,
    OP_SCALE  = 4'd4,
    OP_IMMADD = 4'd5
  } op_e;

  localparam logic [3:0] ALU_BASE   = 4'h2;
  localparam logic [3:0] SEL_SRC1   = 4'h0;
  localparam logic [3:0] SEL_SRC2   = 4'h1;
  localparam logic [3:0] SEL_RESULT = 4'h2;
  localparam logic [3:0] SEL_STATUS = 4'hF;

  typedef logic [2:0] state_e;
  localparam state_e ST_IDLE    = 3'd0;
  localparam state_e ST_WR_SRC1 = 3'd1;
  localparam state_e ST_WR_SRC2 = 3'd2;
  localparam state_e ST_WAIT    = 3'd3;
  localparam state_e ST_POLL    = 3'd4;
  localparam state_e ST_RD      = 3'd5;

  function automatic logic [15:0] mk_addr(input logic [3:0] sel,
                                          input logic [3:0] op,
                                          input logic [3:0] elem);
    return {ALU_BASE, sel, op, elem};
  endfunction

endpackage

// File: rtl/matrix_bus_drv.sv
// Registered bus output stage (address, strobes, write data) plus the read-sample delay
// line that flags when MatrixDataOut is valid, READ_LAT cycles after a read strobe.
module matrix_bus_drv
  import matrix_alu_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              i_wr_req,
  input  logic              i_rd_req,
  input  logic [15:0]       i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_rd_fire,
  output logic [15:0]       o_address,
  output logic              o_nread,
  output logic              o_nwrite,
  output logic [DATA_W-1:0] o_wdata
);

  logic [15:0]       r_address;
  logic              r_nread;
  logic              r_nwrite;
  logic [DATA_W-1:0] r_wdata;
  logic [READ_LAT-1:0] r_rd_pipe;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_address <= '0;
      r_nread   <= 1'b1;
      r_nwrite  <= 1'b1;
      r_wdata   <= '0;
      r_rd_pipe <= '0;
    end else begin
      if (i_wr_req || i_rd_req) r_address <= i_addr;
      r_nwrite <= ~i_wr_req;
      r_nread  <= ~i_rd_req;
      if (i_wr_req) r_wdata <= i_wdata;
      // Delay line starts from the cycle the strobe is on the bus
      r_rd_pipe[0] <= ~r_nread;
      for (int i = 1; i < READ_LAT; i++) r_rd_pipe[i] <= r_rd_pipe[i-1];
    end
  end

  assign o_address = r_address;
  assign o_nread   = r_nread;
  assign o_nwrite  = r_nwrite;
  assign o_wdata   = r_wdata;
  assign o_rd_fire = r_rd_pipe[READ_LAT-1];

endmodule

// File: rtl/matrix_alu_master.sv
// Matrix ALU bus initiator: writes src1/src2 streams, waits for compute, reads results back.
// Define MATRIX_MASTER_POLL_EN to replace the fixed compute wait with STATUS polling.
module matrix_alu_master
  import matrix_alu_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int ELEMS        = 16,
  parameter int READ_LAT     = 1,
  parameter int COMPUTE_WAIT = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_last,
  output logic              busy,
  output logic [15:0]       address,
  output logic              nRead,
  output logic              nWrite,
  output logic [DATA_W-1:0] ExeDataOut,
  input  logic [DATA_W-1:0] MatrixDataOut
);

  localparam logic [3:0] LAST_ELEM = 4'(ELEMS - 1);

  state_e            r_state;
  logic [3:0]        r_op;
  logic [3:0]        r_elem;
  logic              r_cmd_ready;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_res_valid;
  logic              r_res_last;
  logic [DATA_W-1:0] r_res_data;
  logic              r_rd_out;
  logic              r_rd_final;
`ifdef MATRIX_MASTER_POLL_EN
  logic [1:0]        r_poll_cnt;
`else
  localparam int CNT_W = $clog2(COMPUTE_WAIT + 1);
  logic [CNT_W-1:0]  r_wait_cnt;
`endif

  logic        w_cmd_fire;
  logic        w_in_fire;
  logic        w_res_fire;
  logic        w_rd_req;
  logic        w_rd_fire;
  logic [3:0]  w_sel;
  logic [15:0] w_addr;

  assign w_cmd_fire = r_cmd_ready & cmd_valid;
  assign w_in_fire  = r_in_ready & in_valid;
  assign w_res_fire = r_res_valid & res_ready;

  // A result read may issue in the same cycle the previous result is consumed
  always_comb begin
    w_rd_req = 1'b0;
    w_sel    = SEL_RESULT;
    if (r_state == ST_WR_SRC1) w_sel = SEL_SRC1;
    if (r_state == ST_WR_SRC2) w_sel = SEL_SRC2;
    if (r_state == ST_RD)
      w_rd_req = !r_rd_out && !r_rd_final && (!r_res_valid || w_res_fire);
`ifdef MATRIX_MASTER_POLL_EN
    if (r_state == ST_POLL) begin
      w_rd_req = !r_rd_out && (r_poll_cnt == 2'd0);
      w_sel    = SEL_STATUS;
    end
`endif
  end

  assign w_addr = mk_addr(w_sel, r_op, r_elem);

  matrix_bus_drv #(
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_bus_drv (
    .Clk       (Clk),
    .Reset     (Reset),
    .i_wr_req  (w_in_fire),
    .i_rd_req  (w_rd_req),
    .i_addr    (w_addr),
    .i_wdata   (in_data),
    .o_rd_fire (w_rd_fire),
    .o_address (address),
    .o_nread   (nRead),
    .o_nwrite  (nWrite),
    .o_wdata   (ExeDataOut)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_elem      <= '0;
      r_cmd_ready <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_last  <= 1'b0;
      r_rd_out    <= 1'b0;
      r_rd_final  <= 1'b0;
`ifdef MATRIX_MASTER_POLL_EN
      r_poll_cnt  <= '0;
`else
      r_wait_cnt  <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_fire) begin
            r_op        <= cmd_op;
            r_elem      <= '0;
            r_busy      <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_WR_SRC1;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        ST_WR_SRC1: begin
          if (w_in_fire) begin
            if (r_elem == LAST_ELEM) begin
              r_elem  <= '0;
              r_state <= ST_WR_SRC2;
            end else begin
              r_elem <= r_elem + 4'd1;
            end
          end
        end
        ST_WR_SRC2: begin
          if (w_in_fire) begin
            if (r_elem == LAST_ELEM) begin
              r_elem     <= '0;
              r_in_ready <= 1'b0;
`ifdef MATRIX_MASTER_POLL_EN
              r_poll_cnt <= '0;
              r_state    <= ST_POLL;
`else
              r_wait_cnt <= '0;
              r_state    <= ST_WAIT;
`endif
            end else begin
              r_elem <= r_elem + 4'd1;
            end
          end
        end
`ifdef MATRIX_MASTER_POLL_EN
        ST_POLL: begin
          if (w_rd_req) begin
            r_rd_out <= 1'b1;
          end else if (w_rd_fire) begin
            r_rd_out <= 1'b0;
            if (MatrixDataOut[0]) r_state <= ST_RD;
            else                  r_poll_cnt <= 2'd1;
          end else if (r_poll_cnt != 2'd0) begin
            r_poll_cnt <= r_poll_cnt - 2'd1;
          end
        end
`else
        // First WAIT cycle carries the last write strobe, so COMPUTE_WAIT idle cycles follow it
        ST_WAIT: begin
          if (r_wait_cnt == CNT_W'(COMPUTE_WAIT - 1)) r_state <= ST_RD;
          else                                        r_wait_cnt <= r_wait_cnt + 1'b1;
        end
`endif
        ST_RD: begin
          if (w_rd_req) begin
            r_rd_out <= 1'b1;
            if (r_elem == LAST_ELEM) r_rd_final <= 1'b1;
            else                     r_elem <= r_elem + 4'd1;
          end
          if (w_rd_fire) begin
            r_rd_out    <= 1'b0;
            r_res_valid <= 1'b1;
            r_res_last  <= r_rd_final;
          end
          if (w_res_fire) begin
            r_res_valid <= 1'b0;
            r_res_last  <= 1'b0;
            if (r_res_last) begin
              r_busy      <= 1'b0;
              r_rd_final  <= 1'b0;
              r_elem      <= '0;
              r_cmd_ready <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Result data is a pure datapath register; validity is carried by r_res_valid
  always_ff @(posedge Clk) begin
    if (w_rd_fire && (r_state == ST_RD)) r_res_data <= MatrixDataOut;
  end

  assign cmd_ready = r_cmd_ready;
  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign res_valid = r_res_valid;
  assign res_last  = r_res_last;
  assign res_data  = r_res_data;

endmodule
